// File: rtl/dl_stream_fork.sv
// One-to-many valid/ready fork: a single-entry buffer holds each word until
// every output branch has taken it, and branches may take it in different cycles.
module dl_stream_fork #(
  parameter int NUM_BITS = 32,
  parameter int NUM_OUT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NUM_BITS-1:0] in_data,
  output logic [NUM_OUT-1:0]  out_val,
  input  logic [NUM_OUT-1:0]  out_rdy,
  output logic [NUM_BITS-1:0] out_data
);

  logic                buf_val_q;
  logic                buf_val_d;
  logic [NUM_BITS-1:0] buf_data_q;
  logic [NUM_BITS-1:0] buf_data_d;
  logic [NUM_OUT-1:0]  done_q;
  logic [NUM_OUT-1:0]  done_d;
  logic                release_s;
  logic                accept_s;

  // Outputs come straight from state; in_rdy also sees out_rdy so a word can
  // be replaced in the same cycle its last branch takes it.
  always_comb begin
    out_val   = {NUM_OUT{buf_val_q}} & ~done_q;
    out_data  = buf_data_q;
    release_s = buf_val_q & (&(done_q | out_rdy));
    in_rdy    = ~buf_val_q | release_s;
    accept_s  = in_val & in_rdy;
  end

  // Next-state selection: refill beats drain beats fill beats per-branch tracking.
  always_comb begin
    buf_val_d  = buf_val_q;
    buf_data_d = buf_data_q;
    done_d     = done_q;
    if (release_s && accept_s) begin
      buf_val_d  = 1'b1;
      buf_data_d = in_data;
      done_d     = {NUM_OUT{1'b0}};
    end else if (release_s) begin
      buf_val_d  = 1'b0;
      done_d     = {NUM_OUT{1'b0}};
    end else if (accept_s) begin
      buf_val_d  = 1'b1;
      buf_data_d = in_data;
      done_d     = {NUM_OUT{1'b0}};
    end else begin
      done_d     = done_q | (out_val & out_rdy);
    end
  end

  // State registers; reset drops any buffered word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_val_q  <= 1'b0;
      buf_data_q <= {NUM_BITS{1'b0}};
      done_q     <= {NUM_OUT{1'b0}};
    end else begin
      buf_val_q  <= buf_val_d;
      buf_data_q <= buf_data_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dl_stream_fork.sv
// Randomised scoreboard bench for dl_stream_fork with three branches; each
// branch owns a queue of words it still has to receive, in arrival order.
module tb_dl_stream_fork;

  localparam int NB = 32;
  localparam int NO = 3;

  logic          clk;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_data;
  logic [NO-1:0] out_val;
  logic [NO-1:0] out_rdy;
  logic [NB-1:0] out_data;

  int  compared;
  int  mismatched;
  int  stall;
  bit  rdy_rand;

  logic [NB-1:0] sb_q [NO][$];

  dl_stream_fork #(.NUM_BITS(NB), .NUM_OUT(NO)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Random per-branch ready, applied after the main process has had its say.
  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_rdy = NO'($urandom);
  end

  // Monitor: the buffer holds one word, so branch i has a word on offer exactly
  // when its queue is non-empty; the input is ready when every branch with a
  // pending word is ready (or none is pending).
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      for (int i = 0; i < NO; i++) sb_q[i].delete();
    end else begin
      exp_rdy = 1'b1;
      for (int i = 0; i < NO; i++)
        if (sb_q[i].size() != 0 && !out_rdy[i]) exp_rdy = 1'b0;
      chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
      for (int i = 0; i < NO; i++) begin
        chk($sformatf("out_val[%0d]", i), 32'(out_val[i]), 32'(sb_q[i].size() != 0));
        if (sb_q[i].size() != 0) begin
          chk($sformatf("out_data[%0d]", i), out_data, sb_q[i][0]);
          if (out_rdy[i]) void'(sb_q[i].pop_front());
        end
      end
      if (in_val && exp_rdy)
        for (int i = 0; i < NO; i++) sb_q[i].push_back(in_data);
    end
  end

  task automatic send(input logic [NB-1:0] w);
    bit got;
    got = 1'b0;
    in_val  = 1'b1;
    in_data = w;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_rdy) got = 1'b1;
      else stall++;
      @(posedge clk);
      #1;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle();
    in_val  = 1'b0;
    in_data = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    stall      = 0;
    rdy_rand   = 1'b0;
    rst        = 1'b1;
    in_val     = 1'b0;
    in_data    = 32'd0;
    out_rdy    = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_val", 32'(out_val), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Burst of four words with every branch ready: no stalls.
    out_rdy = 3'b111;
    stall   = 0;
    for (int k = 0; k < 4; k++) send(32'hA0 + 32'(k));
    in_val = 1'b0;
    chk("burst_stalls", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    // Branch 1 holds off for three cycles while 0 and 2 take the word early.
    out_rdy = 3'b101;
    send(32'h55);
    in_val = 1'b0;
    chk("hold_out_val", 32'(out_val), 32'b111);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_pending", 32'(out_val), 32'b010);
    end
    out_rdy = 3'b110;
    @(posedge clk);
    #1;
    chk("hold_released", 32'(out_val), 32'd0);
    out_rdy = 3'b111;
    @(posedge clk);
    #1;

    // Back-to-back words through a full buffer.
    stall = 0;
    send(32'h11);
    chk("b2b_first", out_data, 32'h11);
    send(32'h22);
    in_val = 1'b0;
    chk("b2b_second", out_data, 32'h22);
    chk("b2b_stalls", 32'(stall), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic with random branch readiness.
    rdy_rand = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      send($urandom);
    end
    in_val   = 1'b0;
    rdy_rand = 1'b0;
    out_rdy  = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NO; i++)
      chk($sformatf("drain_q[%0d]", i), 32'(sb_q[i].size()), 32'd0);

    // Asynchronous reset with a partly delivered word.
    out_rdy = 3'b001;
    send(32'h77);
    in_val = 1'b0;
    @(posedge clk);
    #1;
    out_rdy = 3'b000;
    chk("pre_reset_val", 32'(out_val), 32'b110);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_out_val", 32'(out_val), 32'd0);
    chk("async_out_data", out_data, 32'd0);
    chk("async_in_rdy", 32'(in_rdy), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Idle with arbitrary branch readiness: nothing moves.
    rdy_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle_cycle();
      @(negedge clk);
      chk("idle_out_val", 32'(out_val), 32'd0);
      chk("idle_out_data", out_data, 32'd0);
    end
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
